// File: rtl/opb_master_arbiter.sv
// Round-robin arbiter sharing one OPB master port between two single-transaction requesters,
// with registered command/handshake outputs and a per-transaction bus timeout.
module opb_master_arbiter #(
  parameter int unsigned BUS_TIMEOUT   = 1000,
  parameter int unsigned TIMEOUT_WIDTH = 10
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic        r0_select,
  input  logic        r0_RNW,
  input  logic [3:0]  r0_BE,
  input  logic [31:0] r0_ABus,
  input  logic [31:0] r0_DBus,
  output logic        r0_xferAck,
  output logic        r0_errAck,
  input  logic        r1_select,
  input  logic        r1_RNW,
  input  logic [3:0]  r1_BE,
  input  logic [31:0] r1_ABus,
  input  logic [31:0] r1_DBus,
  output logic        r1_xferAck,
  output logic        r1_errAck,
  output logic [31:0] rd_data,
  output logic        grant_id,
  output logic        M_request,
  output logic        M_busLock,
  output logic        M_select,
  output logic        M_seqAddr,
  output logic        M_RNW,
  output logic [3:0]  M_BE,
  output logic [31:0] M_ABus,
  output logic [31:0] M_DBus,
  input  logic [31:0] OPB_DBus,
  input  logic        OPB_xferAck,
  input  logic        OPB_errAck,
  input  logic        OPB_MGrant,
  input  logic        OPB_retry,
  input  logic        OPB_timeout
);

  typedef enum logic [1:0] {StIdle, StReq, StBusy, StResp} state_e;

  state_e                   state_q;
  logic [TIMEOUT_WIDTH-1:0] cnt_q;
  logic                     last_grant_q;
  logic                     grant_id_q;
  logic [1:0]               xfer_ack_q;
  logic [1:0]               err_ack_q;
  logic                     request_q;
  logic                     select_q;
  logic                     rnw_q;
  logic [3:0]               be_q;
  logic [31:0]              abus_q;
  logic [31:0]              dbus_q;
  logic [31:0]              rd_data_q;

  logic        pick;
  logic        tmo;
  logic        fail;
  logic        sel_rnw;
  logic [3:0]  sel_be;
  logic [31:0] sel_abus;
  logic [31:0] sel_dbus;

  // On contention the requester that did not own the previous grant wins.
  assign pick     = (r0_select && r1_select) ? ~last_grant_q : r1_select;
  assign sel_rnw  = pick ? r1_RNW  : r0_RNW;
  assign sel_be   = pick ? r1_BE   : r0_BE;
  assign sel_abus = pick ? r1_ABus : r0_ABus;
  assign sel_dbus = pick ? r1_DBus : r0_DBus;
  assign tmo      = (cnt_q == TIMEOUT_WIDTH'(BUS_TIMEOUT));
  assign fail     = OPB_errAck | OPB_timeout | tmo;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      xfer_ack_q   <= 2'b00;
      err_ack_q    <= 2'b00;
      request_q    <= 1'b0;
      select_q     <= 1'b0;
      rnw_q        <= 1'b0;
      be_q         <= '0;
      abus_q       <= '0;
      dbus_q       <= '0;
      rd_data_q    <= '0;
    end else begin
      xfer_ack_q <= 2'b00;
      err_ack_q  <= 2'b00;
      unique case (state_q)
        StIdle: begin
          if (r0_select || r1_select) begin
            rnw_q        <= sel_rnw;
            be_q         <= sel_be;
            abus_q       <= sel_abus;
            // Reads never drive write data onto the bus.
            dbus_q       <= sel_rnw ? 32'h0 : sel_dbus;
            grant_id_q   <= pick;
            last_grant_q <= pick;
            cnt_q        <= '0;
            request_q    <= 1'b1;
            state_q      <= StReq;
          end
        end
        StReq: begin
          cnt_q <= cnt_q + TIMEOUT_WIDTH'(1);
          if (tmo) begin
            err_ack_q[grant_id_q] <= 1'b1;
            rd_data_q             <= OPB_DBus;
            request_q             <= 1'b0;
            state_q               <= StResp;
          end else if (OPB_MGrant) begin
            select_q <= 1'b1;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q + TIMEOUT_WIDTH'(1);
          if (fail || OPB_xferAck) begin
            if (fail) err_ack_q[grant_id_q] <= 1'b1;
            else      xfer_ack_q[grant_id_q] <= 1'b1;
            rd_data_q <= OPB_DBus;
            request_q <= 1'b0;
            select_q  <= 1'b0;
            state_q   <= StResp;
          end else if (OPB_retry) begin
            // last_grant keeps the retried owner so a waiting peer goes next.
            request_q <= 1'b0;
            select_q  <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign r0_xferAck = xfer_ack_q[0];
  assign r1_xferAck = xfer_ack_q[1];
  assign r0_errAck  = err_ack_q[0];
  assign r1_errAck  = err_ack_q[1];
  assign rd_data    = rd_data_q;
  assign grant_id   = grant_id_q;
  assign M_request  = request_q;
  assign M_select   = select_q;
  assign M_busLock  = 1'b0;
  assign M_seqAddr  = 1'b0;
  assign M_RNW      = rnw_q;
  assign M_BE       = be_q;
  assign M_ABus     = abus_q;
  assign M_DBus     = dbus_q;

endmodule

// File: tb/tb_opb_master_arbiter.sv
// Bench for opb_master_arbiter: directed scenarios plus random transactions, each checked
// cycle by cycle against a per-transaction timeline derived from the arbitration rules.
module tb_opb_master_arbiter;
  localparam int unsigned TMO = 8;
  localparam int KXfer = 0, KErr = 1, KTmo = 2, KRetry = 3, KBoth = 4, KNone = 5;

  logic        OPB_Clk, OPB_Rst_n;
  logic        r0_select, r0_RNW, r0_xferAck, r0_errAck;
  logic [3:0]  r0_BE;
  logic [31:0] r0_ABus, r0_DBus;
  logic        r1_select, r1_RNW, r1_xferAck, r1_errAck;
  logic [3:0]  r1_BE;
  logic [31:0] r1_ABus, r1_DBus;
  logic [31:0] rd_data;
  logic        grant_id;
  logic        M_request, M_busLock, M_select, M_seqAddr, M_RNW;
  logic [3:0]  M_BE;
  logic [31:0] M_ABus, M_DBus, OPB_DBus;
  logic        OPB_xferAck, OPB_errAck, OPB_MGrant, OPB_retry, OPB_timeout;
  logic [3:0]  acks;

  assign acks = {r1_errAck, r1_xferAck, r0_errAck, r0_xferAck};

  opb_master_arbiter #(.BUS_TIMEOUT(TMO), .TIMEOUT_WIDTH(10)) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst_n(OPB_Rst_n),
    .r0_select(r0_select), .r0_RNW(r0_RNW), .r0_BE(r0_BE), .r0_ABus(r0_ABus),
    .r0_DBus(r0_DBus), .r0_xferAck(r0_xferAck), .r0_errAck(r0_errAck),
    .r1_select(r1_select), .r1_RNW(r1_RNW), .r1_BE(r1_BE), .r1_ABus(r1_ABus),
    .r1_DBus(r1_DBus), .r1_xferAck(r1_xferAck), .r1_errAck(r1_errAck),
    .rd_data(rd_data), .grant_id(grant_id),
    .M_request(M_request), .M_busLock(M_busLock), .M_select(M_select),
    .M_seqAddr(M_seqAddr), .M_RNW(M_RNW), .M_BE(M_BE), .M_ABus(M_ABus), .M_DBus(M_DBus),
    .OPB_DBus(OPB_DBus), .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
    .OPB_MGrant(OPB_MGrant), .OPB_retry(OPB_retry), .OPB_timeout(OPB_timeout)
  );

  initial OPB_Clk = 1'b0;
  always #5 OPB_Clk = ~OPB_Clk;

  int          n_cmp, n_bad;
  // Reference model: requester intent and expected arbiter-visible state.
  bit          pend[2], drp[2], preset[2];
  logic        m_rnw[2];
  logic [3:0]  m_be[2];
  logic [31:0] m_ab[2], m_db[2];
  bit          last_g, exp_gid, fix_rd;
  logic [31:0] exp_rd, fix_rd_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctl"}, 32'({M_request, M_select, M_busLock, M_seqAddr}), 32'h0);
    check_eq({tag, "_ack"}, 32'(acks), 32'h0);
  endtask

  task automatic rand_cmd(input int i);
    m_rnw[i] = 1'($urandom);
    m_be[i]  = 4'($urandom);
    m_ab[i]  = $urandom;
    m_db[i]  = $urandom;
  endtask

  task automatic set_cmd(input int i, input logic rnw, input logic [3:0] be,
                         input logic [31:0] ab, input logic [31:0] db);
    m_rnw[i] = rnw; m_be[i] = be; m_ab[i] = ab; m_db[i] = db; preset[i] = 1'b1;
  endtask

  // Requesters without a live select wiggle their fields to expose any combinational path.
  task automatic drive_req();
    r0_select = pend[0] && !drp[0];
    r1_select = pend[1] && !drp[1];
    r0_RNW  = r0_select ? m_rnw[0] : 1'($urandom);
    r0_BE   = r0_select ? m_be[0]  : 4'($urandom);
    r0_ABus = r0_select ? m_ab[0]  : $urandom;
    r0_DBus = r0_select ? m_db[0]  : $urandom;
    r1_RNW  = r1_select ? m_rnw[1] : 1'($urandom);
    r1_BE   = r1_select ? m_be[1]  : 4'($urandom);
    r1_ABus = r1_select ? m_ab[1]  : $urandom;
    r1_DBus = r1_select ? m_db[1]  : $urandom;
  endtask

  task automatic clear_opb();
    OPB_DBus = '0; OPB_xferAck = 0; OPB_errAck = 0; OPB_MGrant = 0;
    OPB_retry = 0; OPB_timeout = 0;
  endtask

  task automatic reset_model();
    last_g = 1'b1; exp_gid = 1'b0; exp_rd = '0;
  endtask

  // Starts at an IDLE-cycle negedge. gd: REQ cycles without MGrant; b: BUSY cycle of response.
  task automatic txn(input bit new0, input bit new1, input int gd, input int b,
                     input int kind, input bit drop, input int abort_c);
    int t, resp, e, w;
    bit ek_err, ek_retry, aborted;
    logic [31:0] cap;
    @(negedge OPB_Clk);
    check_quiet("idle");
    check_eq("idle_rd", rd_data, exp_rd);
    check_eq("idle_gid", 32'(grant_id), 32'(exp_gid));
    if (new0 && !pend[0]) begin pend[0] = 1'b1; if (!preset[0]) rand_cmd(0); end
    if (new1 && !pend[1]) begin pend[1] = 1'b1; if (!preset[1]) rand_cmd(1); end
    preset[0] = 1'b0; preset[1] = 1'b0;
    clear_opb();
    drive_req();
    if (!pend[0] && !pend[1]) return;
    w = (pend[0] && pend[1]) ? int'(!last_g) : int'(pend[1]);
    last_g = w[0]; exp_gid = w[0];
    // Cycle 1 is the first REQ cycle; the internal timeout is detected in cycle TMO+1.
    t = TMO + 1;
    resp = (kind == KNone) ? 100000 : gd + 1 + b;
    e = (resp < t) ? resp : t;
    ek_retry = (resp < t) && (kind == KRetry);
    ek_err = (resp >= t) || kind == KErr || kind == KTmo || kind == KBoth;
    cap = exp_rd;
    aborted = 1'b0;
    for (int c = 1; c <= e && !aborted; c++) begin
      @(negedge OPB_Clk);
      check_eq("req", 32'(M_request), 32'h1);
      check_eq("sel", 32'(M_select), 32'(c >= gd + 2));
      check_eq("fixed", 32'({M_busLock, M_seqAddr}), 32'h0);
      check_eq("gid", 32'(grant_id), 32'(w));
      check_eq("rnw", 32'(M_RNW), 32'(m_rnw[w]));
      check_eq("be", 32'(M_BE), 32'(m_be[w]));
      check_eq("abus", M_ABus, m_ab[w]);
      check_eq("dbus", M_DBus, m_rnw[w] ? 32'h0 : m_db[w]);
      check_eq("busy_ack", 32'(acks), 32'h0);
      check_eq("busy_rd", rd_data, exp_rd);
      if (c == abort_c) begin
        #2 OPB_Rst_n = 1'b0;
        #1 check_eq("rst_async", 32'({M_request, M_select}), 32'h0);
        check_eq("rst_async_ack", 32'(acks), 32'h0);
        @(posedge OPB_Clk);
        #1 check_quiet("rst_hold");
        check_eq("rst_rd", rd_data, 32'h0);
        clear_opb();
        reset_model();
        OPB_Rst_n = 1'b1;
        aborted = 1'b1;
      end else begin
        if (drop && c == 1) drp[w] = 1'b1;
        drive_req();
        OPB_MGrant  = (c == gd + 1);
        OPB_DBus    = fix_rd ? fix_rd_val : $urandom;
        OPB_xferAck = (c == resp) && (kind == KXfer || kind == KBoth);
        OPB_errAck  = (c == resp) && (kind == KErr || kind == KBoth);
        OPB_timeout = (c == resp) && (kind == KTmo);
        OPB_retry   = (c == resp) && (kind == KRetry);
        cap = OPB_DBus;
      end
    end
    if (aborted || ek_retry) return;
    @(negedge OPB_Clk);
    exp_rd = cap;
    check_eq("resp_ctl", 32'({M_request, M_select}), 32'h0);
    check_eq("resp_ack", 32'(acks), 32'h1 << (w * 2 + int'(ek_err)));
    check_eq("resp_rd", rd_data, exp_rd);
    check_eq("resp_gid", 32'(grant_id), 32'(w));
    pend[w] = 1'b0; drp[w] = 1'b0;
    clear_opb();
    drive_req();
  endtask

  task automatic do_reset();
    #2 OPB_Rst_n = 1'b0;
    @(posedge OPB_Clk);
    #1 check_quiet("rst");
    reset_model();
    OPB_Rst_n = 1'b1;
  endtask

  int rk, rgd, rb;

  initial begin
    n_cmp = 0; n_bad = 0;
    OPB_Rst_n = 1'b0;
    clear_opb();
    drive_req();
    reset_model();
    #1;
    check_quiet("por");
    check_eq("por_cmd", 32'({M_RNW, M_BE}), 32'h0);
    check_eq("por_abus", M_ABus, 32'h0);
    check_eq("por_dbus", M_DBus, 32'h0);
    check_eq("por_rd", rd_data, 32'h0);
    check_eq("por_gid", 32'(grant_id), 32'h0);
    @(posedge OPB_Clk);
    #1 OPB_Rst_n = 1'b1;

    // r0 write: MGrant in first REQ cycle, xferAck on third BUSY cycle.
    set_cmd(0, 1'b0, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
    txn(1, 0, 0, 3, KXfer, 0, 0);

    // Simultaneous requests after reset, each re-requesting after its ack.
    do_reset();
    repeat (4) txn(1, 1, 0, 1, KXfer, 0, 0);
    txn(0, 0, 0, 1, KXfer, 0, 0);

    // r1 read with fixed return data, then a few idle cycles holding rd_data.
    set_cmd(1, 1'b1, 4'hF, 32'h0000_2000, 32'hFFFF_FFFF);
    fix_rd = 1'b1; fix_rd_val = 32'h1234_5678;
    txn(0, 1, 1, 2, KXfer, 0, 0);
    fix_rd = 1'b0;
    check_eq("rd_hold", exp_rd, 32'h1234_5678);
    repeat (3) txn(0, 0, 0, 1, KXfer, 0, 0);

    // Internal timeout with no OPB response, then a normal transaction.
    txn(1, 0, 0, 20, KNone, 0, 0);
    txn(1, 0, 0, 2, KXfer, 0, 0);

    // Retry hands the bus to the waiting peer; errAck beats xferAck.
    txn(0, 1, 0, 1, KXfer, 0, 0);
    txn(1, 1, 0, 2, KRetry, 0, 0);
    txn(0, 0, 0, 1, KXfer, 0, 0);
    txn(0, 0, 1, 1, KBoth, 0, 0);

    // Reset mid-BUSY while r1 waits; r0 must win the first contention afterwards.
    txn(0, 1, 0, 1, KXfer, 0, 0);
    txn(1, 1, 0, 5, KXfer, 0, 3);
    txn(0, 0, 0, 1, KXfer, 0, 0);
    txn(0, 0, 0, 1, KXfer, 0, 0);

    repeat (150) begin
      rk  = int'($urandom_range(0, 5));
      rgd = int'($urandom_range(0, 9));
      rb  = int'($urandom_range(1, 6));
      txn(1'($urandom), 1'($urandom), rgd, rb, rk,
          (rk != KRetry) && ($urandom_range(0, 3) == 0), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
